i_cache_control: RTL and testbench
==================================

# i_cache_control

Sequencing FSM for the prefetching instruction-cache datapath. It decides hit/miss from the datapath hit flags and serves demand misses through the cacheline adaptor. It also launches one-block-lookahead (OBL) prefetches of line+1 into the LRU victim way, and drives every select, load and busy-bit strobe the datapath exposes. It sits between the CPU fetch port and the datapath, and owns the single memory port.

## Interface
- No parameters; geometry is fixed at 2 ways, 8 sets, 32-byte lines.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU fetch request; address is held stable until mem_resp
- mem_resp  out  1  CPU fetch complete; data is valid the same cycle
- pmem_read  out  1  line read request to the cacheline adaptor
- pmem_resp  in  1  adaptor line-return strobe, one cycle
- instr_line_hit, hit1, lru_out  in  1 each  demand-line status from the datapath
- obl_line_hit, obl_lru_out  in  1 each  status of line+1 from the datapath
- way_sel, load_cache, load_lru, lru_index_sel  out  1 each  way, fill and LRU control
- prefetch_sel, load_prefetch_buffer  out  1 each  prefetch address path control
- load_busy, busy_load_sel, busy_index_sel, busy_i  out  1 each  busy-bit write control

## Operation
- States: IDLE, FETCH, PREFETCH. Reset enters IDLE; the internal pf_way register resets to 0.
- All outputs are 0 in reset and whenever no rule below asserts them. Outputs are Moore/Mealy combinational from state and inputs.
- **IDLE, demand hit** (mem_read & instr_line_hit):
  - mem_resp=1, way_sel=hit1, load_lru=1, lru_index_sel=0.
- **IDLE, demand miss** (mem_read & ~instr_line_hit):
  - go to FETCH; no response this cycle.
- **IDLE, prefetch launch** (demand hit & ~obl_line_hit):
  - load_prefetch_buffer=1.
  - Mark the victim busy: load_busy=1, busy_i=1, busy_index_sel=1, busy_load_sel=obl_lru_out.
  - pf_way<=obl_lru_out; go to PREFETCH.
- **FETCH:**
  - pmem_read=1, prefetch_sel=0, way_sel=lru_out.
  - On pmem_resp: load_cache=1, load_lru=1, lru_index_sel=0; go to IDLE. The re-lookup hits next cycle.
- **PREFETCH, waiting:**
  - pmem_read=1, prefetch_sel=1.
  - Demand hits are still served as in IDLE, but no new prefetch may launch.
  - Demand misses stall with no response.
- **PREFETCH, on pmem_resp (fill cycle):**
  - prefetch_sel=1, way_sel=pf_way, load_cache=1.
  - load_lru=1, lru_index_sel=1; the LRU then points away from pf_way.
  - Clear busy: load_busy=1, busy_i=0, busy_index_sel=0, busy_load_sel=pf_way.
  - mem_resp=0 this cycle even on a hit, because way_sel is owned by the fill. Go to IDLE.
- A demand to the line being prefetched sees busy=1, so it reads as a miss. It stalls through PREFETCH and hits in IDLE afterwards; it is never fetched twice.
- Only one memory transaction is outstanding at any time.

## Timing
- Hit latency: 0 cycles; mem_resp is in the same cycle as mem_read.
- Miss latency: N+2 cycles, where N is the adaptor latency from pmem_read to pmem_resp.
  - Cycle 0: detect the miss.
  - Cycles 1..N: FETCH.
  - Cycle N+1: fill.
  - Cycle N+2: hit response.
- pmem_read holds high continuously from state entry through the pmem_resp cycle, then drops the next cycle.
- Prefetch launch adds no cycles to the triggering hit. pmem_read rises the next cycle.
- Demand miss arriving during PREFETCH:
  - Wait until the prefetch completes and the FSM returns to IDLE.
  - IDLE then detects the miss; FETCH begins one cycle later.
- Reset mid-FETCH or mid-PREFETCH:
  - Next cycle is IDLE with pmem_read=0.
  - Datapath busy bits clear on the same rst.
  - The adaptor is reset together with the controller, so no stale pmem_resp arrives.
- pmem_resp in IDLE is ignored.

## Configuration
- Macro I_CACHE_PREFETCH_EN.
- **Defined:** behaviour as above.
- **Undefined:**
  - PREFETCH is never entered.
  - load_prefetch_buffer, load_busy, busy_i, prefetch_sel, lru_index_sel and busy_index_sel are tied to 0.
  - The block becomes a plain IDLE/FETCH miss handler; hit and miss latencies are unchanged.

## Test plan
- Reset, then mem_read to an empty cache with N=4:
  - pmem_read high for 4 cycles, prefetch_sel=0.
  - Fill cycle with load_cache=1 and way_sel=lru_out.
  - mem_resp in cycle 6.
- Hit on line A (0x100) while line A+1 (0x120) is absent and obl_lru_out=1:
  - Same cycle: mem_resp=1, load_prefetch_buffer=1, load_busy=1, busy_load_sel=1, busy_i=1.
  - Next cycle: pmem_read=1, prefetch_sel=1.
- Demand 0x120 issued during that prefetch:
  - mem_resp stays 0 through the fill and pmem_read is not re-issued.
  - mem_resp=1 the cycle after the fill, with way_sel=1.
- Demand hit to another set during PREFETCH:
  - mem_resp=1 the same cycle while pmem_read stays high.
  - If the hit lands on the fill cycle, mem_resp is delayed one cycle.
- rst asserted on the second FETCH cycle:
  - Next cycle pmem_read=0 and all outputs are 0.
  - A subsequent mem_read starts a fresh miss.
- With I_CACHE_PREFETCH_EN undefined, repeat scenario 2:
  - load_prefetch_buffer and load_busy stay 0 and no pmem_read follows the hit.

Source files
------------

// File: rtl/i_cache_control.sv
// rtl/i_cache_control.sv - sequencing FSM for the prefetching instruction cache
//
// Decides hit/miss from the datapath hit flags, serves demand misses through
// the cacheline adaptor, and (with I_CACHE_PREFETCH_EN defined) launches
// one-block-lookahead prefetches of line+1 into the LRU victim way.
// Without I_CACHE_PREFETCH_EN the block is a plain IDLE/FETCH miss handler.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_read / mem_resp       CPU fetch request / completion (hit is same cycle)
//   pmem_read / pmem_resp     line read request / one-cycle line-return strobe
//   instr_line_hit, hit1      demand line hit and the way it hit in
//   lru_out                   LRU way of the demand set (miss fill target)
//   obl_line_hit, obl_lru_out line+1 present / LRU way of the line+1 set
//   way_sel, load_cache       way select and data/tag array write
//   load_lru, lru_index_sel   LRU update, index from demand(0) or prefetch(1)
//   prefetch_sel              memory address from demand(0) or prefetch(1)
//   load_prefetch_buffer      capture the line+1 address
//   load_busy, busy_load_sel  busy-bit write strobe and the way written
//   busy_index_sel, busy_i    busy index from line+1(1) or prefetch(0), value

module i_cache_control (
    input  logic clk,
    input  logic rst,
    input  logic mem_read,
    output logic mem_resp,
    output logic pmem_read,
    input  logic pmem_resp,
    input  logic instr_line_hit,
    input  logic hit1,
    input  logic lru_out,
    input  logic obl_line_hit,
    input  logic obl_lru_out,
    output logic way_sel,
    output logic load_cache,
    output logic load_lru,
    output logic lru_index_sel,
    output logic prefetch_sel,
    output logic load_prefetch_buffer,
    output logic load_busy,
    output logic busy_load_sel,
    output logic busy_index_sel,
    output logic busy_i
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FETCH    = 2'd1;
`ifdef I_CACHE_PREFETCH_EN
    localparam logic [1:0] S_PREFETCH = 2'd2;

    // Way being filled by the outstanding prefetch; it owns way_sel on the fill.
    logic pf_way;
`else
    logic unused_obl;
    assign unused_obl = obl_line_hit ^ obl_lru_out;
`endif

    logic [1:0] state;
    logic [1:0] state_next;

    always_comb begin
        state_next           = state;
        mem_resp             = 1'b0;
        pmem_read            = 1'b0;
        way_sel              = 1'b0;
        load_cache           = 1'b0;
        load_lru             = 1'b0;
        lru_index_sel        = 1'b0;
        prefetch_sel         = 1'b0;
        load_prefetch_buffer = 1'b0;
        load_busy            = 1'b0;
        busy_load_sel        = 1'b0;
        busy_index_sel       = 1'b0;
        busy_i               = 1'b0;

        // Outputs are held quiet while reset is asserted, whatever the state.
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (mem_read) begin
                        if (instr_line_hit) begin
                            mem_resp = 1'b1;
                            way_sel  = hit1;
                            load_lru = 1'b1;
`ifdef I_CACHE_PREFETCH_EN
                            // Line+1 absent: reserve the victim way by marking
                            // it busy so a demand to that line reads as a miss
                            // until the prefetch fill lands.
                            if (!obl_line_hit) begin
                                load_prefetch_buffer = 1'b1;
                                load_busy            = 1'b1;
                                busy_i               = 1'b1;
                                busy_index_sel       = 1'b1;
                                busy_load_sel        = obl_lru_out;
                                state_next           = S_PREFETCH;
                            end
`endif
                        end else begin
                            state_next = S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    pmem_read = 1'b1;
                    way_sel   = lru_out;
                    if (pmem_resp) begin
                        load_cache = 1'b1;
                        load_lru   = 1'b1;
                        state_next = S_IDLE;
                    end
                end

`ifdef I_CACHE_PREFETCH_EN
                S_PREFETCH: begin
                    pmem_read    = 1'b1;
                    prefetch_sel = 1'b1;
                    if (pmem_resp) begin
                        // Fill cycle: way_sel belongs to the fill, so any
                        // demand hit this cycle waits one cycle for IDLE.
                        way_sel        = pf_way;
                        load_cache     = 1'b1;
                        load_lru       = 1'b1;
                        lru_index_sel  = 1'b1;
                        load_busy      = 1'b1;
                        busy_load_sel  = pf_way;
                        state_next     = S_IDLE;
                    end else if (mem_read && instr_line_hit) begin
                        // Hits proceed under the prefetch; misses stall.
                        mem_resp = 1'b1;
                        way_sel  = hit1;
                        load_lru = 1'b1;
                    end
                end
`endif

                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef I_CACHE_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_way <= 1'b0;
        end else if (state == S_IDLE && state_next == S_PREFETCH) begin
            pf_way <= obl_lru_out;
        end
    end
`endif

endmodule

// File: tb/tb_i_cache_control.sv
// tb/tb_i_cache_control.sv - directed self-checking bench for i_cache_control

module tb_i_cache_control;

    logic clk = 1'b0;
    logic rst;
    logic mem_read, mem_resp, pmem_read, pmem_resp;
    logic instr_line_hit, hit1, lru_out, obl_line_hit, obl_lru_out;
    logic way_sel, load_cache, load_lru, lru_index_sel, prefetch_sel;
    logic load_prefetch_buffer, load_busy, busy_load_sel, busy_index_sel, busy_i;

    int total = 0;
    int bad   = 0;

    // Output bit masks, in the order of the packed observation vector.
    localparam logic [11:0] R   = 12'h800; // mem_resp
    localparam logic [11:0] PR  = 12'h400; // pmem_read
    localparam logic [11:0] WS  = 12'h200; // way_sel
    localparam logic [11:0] LC  = 12'h100; // load_cache
    localparam logic [11:0] LL  = 12'h080; // load_lru
    localparam logic [11:0] LIS = 12'h040; // lru_index_sel
    localparam logic [11:0] PS  = 12'h020; // prefetch_sel
    localparam logic [11:0] LPB = 12'h010; // load_prefetch_buffer
    localparam logic [11:0] LB  = 12'h008; // load_busy
    localparam logic [11:0] BLS = 12'h004; // busy_load_sel
    localparam logic [11:0] BIS = 12'h002; // busy_index_sel
    localparam logic [11:0] BI  = 12'h001; // busy_i
    localparam logic [11:0] Z   = 12'h000;

    logic [11:0] outs;
    assign outs = {mem_resp, pmem_read, way_sel, load_cache, load_lru, lru_index_sel,
                   prefetch_sel, load_prefetch_buffer, load_busy, busy_load_sel,
                   busy_index_sel, busy_i};

    i_cache_control dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_resp(pmem_resp),
        .instr_line_hit(instr_line_hit), .hit1(hit1), .lru_out(lru_out),
        .obl_line_hit(obl_line_hit), .obl_lru_out(obl_lru_out),
        .way_sel(way_sel), .load_cache(load_cache), .load_lru(load_lru),
        .lru_index_sel(lru_index_sel), .prefetch_sel(prefetch_sel),
        .load_prefetch_buffer(load_prefetch_buffer), .load_busy(load_busy),
        .busy_load_sel(busy_load_sel), .busy_index_sel(busy_index_sel),
        .busy_i(busy_i)
    );

    always #5 clk = ~clk;

    // Move to the next cycle; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample outputs 2 units after the edge, after inputs have settled.
    task automatic chk(input string tag, input logic [11:0] exp);
        #1;
        total++;
        assert (outs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, outs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic hit, input logic h1,
                         input logic lru, input logic ohit, input logic olru,
                         input logic resp);
        mem_read       = rd;
        instr_line_hit = hit;
        hit1           = h1;
        lru_out        = lru;
        obl_line_hit   = ohit;
        obl_lru_out    = olru;
        pmem_resp      = resp;
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 0, 0, 1, 1, 0, 1);
        tick();
        chk("reset_quiet", Z);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("post_reset_idle", Z);

        // Demand miss to an empty cache, adaptor returns in cycle 5.
        tick();
        drive(1, 0, 0, 1, 1, 0, 0);
        chk("miss_c0_detect", Z);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("miss_c%0d_fetch", c), PR | WS);
        end
        tick();
        pmem_resp = 1'b1;
        chk("miss_c5_fill", PR | WS | LC | LL);
        tick();
        drive(1, 1, 1, 1, 1, 0, 0);
        chk("miss_c6_hit", R | WS | LL);

        // pmem_resp seen in IDLE does nothing.
        tick();
        drive(0, 0, 0, 0, 1, 0, 1);
        chk("idle_stray_resp", Z);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("idle_after_stray", Z);

        // Hit on line A with line A+1 absent, victim way 1.
        tick();
        drive(1, 1, 0, 0, 0, 1, 0);
`ifdef I_CACHE_PREFETCH_EN
        chk("pf_launch", R | LL | LPB | LB | BLS | BIS | BI);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("pf_wait_read", PR | PS);

        // Demand to line A+1 reads as a miss (busy) and stalls.
        tick();
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("pf_busy_stall1", PR | PS);
        tick();
        chk("pf_busy_stall2", PR | PS);
        tick();
        pmem_resp = 1'b1;
        chk("pf_fill_way1", PR | PS | WS | LC | LL | LIS | LB | BLS);
        tick();
        drive(1, 1, 1, 0, 1, 0, 0);
        chk("pf_line_hit_after", R | WS | LL);

        // Second prefetch into way 0, with hits to other sets under it.
        tick();
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("pf2_launch", R | WS | LL | LPB | LB | BIS | BI);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("pf2_hit_under", R | LL | PR | PS);
        tick();
        pmem_resp = 1'b1;
        chk("pf2_hit_on_fill", PR | PS | LC | LL | LIS | LB);
        tick();
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("pf2_delayed_hit", R | LL);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("pf2_idle", Z);
`else
        chk("nopf_hit_only", R | LL);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("nopf_no_read1", Z);
        tick();
        chk("nopf_no_read2", Z);
`endif

        // Reset on the second FETCH cycle.
        tick();
        drive(1, 0, 0, 1, 1, 0, 0);
        chk("rst_miss_detect", Z);
        tick();
        chk("rst_fetch1", PR | WS);
        tick();
        rst = 1'b1;
        chk("rst_during", Z);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 1, 0, 0);
        chk("rst_after_quiet", Z);
        tick();
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("rst_fresh_detect", Z);
        tick();
        chk("rst_fresh_fetch", PR);
        tick();
        pmem_resp = 1'b1;
        chk("rst_fresh_fill", PR | LC | LL);
        tick();
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("rst_fresh_hit", R | LL);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("final_idle", Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
